// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
package add_sub_pkg;

    // Operation select as decoded by the ALU; maps directly onto sub_i.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } add_sub_op_e;

    // Width-independent control bits of one pipeline stage. The operand and
    // partial-sum words are parameter-sized and travel alongside this struct.
    typedef struct packed {
        logic valid;      // stage holds a live operation
        logic carry;      // carry out of the most recently resolved chunk
        logic carry_msb;  // carry into bit WIDTH-1, captured by the last stage
        logic zero;       // partial sum word is all zeros
    } stage_ctrl_t;

    // Bits resolved per stage; zero stages yields zero rather than a divide fault.
    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

endpackage

// File: rtl/add_sub_stage.sv
// One pipeline stage: resolves chunk IDX of the carry chain and registers the
// partial sum, the chunk carry-out and the skewed operands for later stages.
module add_sub_stage
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8,
    parameter int unsigned IDX   = 0,
    parameter bit          LAST  = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               adv,
    input  stage_ctrl_t        prev_ctrl,
    input  logic [WIDTH-1:0]   prev_a,
    input  logic [WIDTH-1:0]   prev_b,
    input  logic [WIDTH-1:0]   prev_sum,
    output stage_ctrl_t        ctrl,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   sum
);

    localparam int unsigned LO = IDX * CHUNK;

    logic [CHUNK:0]   carries;
    logic [CHUNK-1:0] chunk_sum;
    logic [WIDTH-1:0] sum_next;
    stage_ctrl_t      ctrl_next;
    logic             unused_zero;

    // The zero flag is recomputed from the full word at every stage.
    assign unused_zero = prev_ctrl.zero;
    assign carries[0]  = prev_ctrl.carry;

    for (genvar i = 0; i < CHUNK; i++) begin : g_ripple
        fa u_fa (
            .a     (prev_a[LO + i]),
            .b     (prev_b[LO + i]),
            .c     (carries[i]),
            .sum   (chunk_sum[i]),
            .carry (carries[i + 1])
        );
    end

    // Merge this chunk into the partial sum and derive the next control word.
    always_comb begin
        sum_next              = prev_sum;
        sum_next[LO +: CHUNK] = chunk_sum;
        ctrl_next.valid       = prev_ctrl.valid;
        ctrl_next.carry       = carries[CHUNK];
        ctrl_next.carry_msb   = LAST ? carries[CHUNK-1] : prev_ctrl.carry_msb;
        ctrl_next.zero        = ~|sum_next;
    end

    // Stage register: loads on advance, holds otherwise; cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl <= '0;
            a    <= '0;
            b    <= '0;
            sum  <= '0;
        end else if (adv) begin
            ctrl <= ctrl_next;
            a    <= prev_a;
            b    <= prev_b;
            sum  <= sum_next;
        end
    end

endmodule

// File: rtl/fa.sv
// Single-bit full adder, the building block of each stage's ripple chain.
module fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor split into STAGES carry-chain chunks,
// with valid/ready handshake, backpressure and carry/overflow/zero flags.
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             zero_o
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if (STAGES == 0 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("add_sub_pipe: WIDTH must be a non-zero multiple of STAGES");
    end

    add_sub_op_e      op;
    logic             adv;
    stage_ctrl_t      feed_ctrl;
    logic [WIDTH-1:0] feed_b;
    logic             unused_skew;

    stage_ctrl_t      ctrl_pipe [STAGES];
    logic [WIDTH-1:0] a_pipe    [STAGES];
    logic [WIDTH-1:0] b_pipe    [STAGES];
    logic [WIDTH-1:0] sum_pipe  [STAGES];

    assign op = sub_i ? OP_SUB : OP_ADD;

    // Every stage moves together; a full output that is not taken stalls all.
    assign adv     = ready_i | ~ctrl_pipe[STAGES-1].valid;
    assign ready_o = adv;

    // Stage-0 operand conditioning: subtract is A + ~B + 1, carry_i ignored.
    always_comb begin
        feed_ctrl       = '0;
        feed_ctrl.valid = valid_i;
        feed_ctrl.carry = carry_i;
        feed_b          = b_i;
        if (op == OP_SUB) begin
            feed_ctrl.carry = 1'b1;
            feed_b          = ~b_i;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_ctrl_t      prev_ctrl;
        logic [WIDTH-1:0] prev_a;
        logic [WIDTH-1:0] prev_b;
        logic [WIDTH-1:0] prev_sum;

        if (k == 0) begin : g_feed
            assign prev_ctrl = feed_ctrl;
            assign prev_a    = a_i;
            assign prev_b    = feed_b;
            assign prev_sum  = '0;
        end else begin : g_link
            assign prev_ctrl = ctrl_pipe[k-1];
            assign prev_a    = a_pipe[k-1];
            assign prev_b    = b_pipe[k-1];
            assign prev_sum  = sum_pipe[k-1];
        end

        add_sub_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k),
            .LAST  (k == STAGES - 1)
        ) u_stage (
            .clk       (clk_i),
            .rst_n     (rst_ni),
            .adv       (adv),
            .prev_ctrl (prev_ctrl),
            .prev_a    (prev_a),
            .prev_b    (prev_b),
            .prev_sum  (prev_sum),
            .ctrl      (ctrl_pipe[k]),
            .a         (a_pipe[k]),
            .b         (b_pipe[k]),
            .sum       (sum_pipe[k])
        );
    end

    // Fully consumed operand skew leaving the last stage.
    assign unused_skew = ^{a_pipe[STAGES-1], b_pipe[STAGES-1]};

    assign valid_o    = ctrl_pipe[STAGES-1].valid;
    assign sum_o      = sum_pipe[STAGES-1];
    assign carry_o    = ctrl_pipe[STAGES-1].carry;
    assign overflow_o = ctrl_pipe[STAGES-1].carry ^ ctrl_pipe[STAGES-1].carry_msb;
    assign zero_o     = ctrl_pipe[STAGES-1].zero;

endmodule
